// File: rtl/a2_slot_initiator.sv
// Apple II slot-bus initiator: one DEVSEL bus cycle per request, free-running
// phi0/phi1 timing derived from a clk_logic_i divider, registered bus outputs.
module a2_slot_initiator #(
  parameter logic [2:0] SLOT        = 3'd7,
  parameter int         HALF_CYCLES = 27,
  parameter logic [7:0] FLOAT_DATA  = 8'hFF
) (
  input  logic        clk_logic_i,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rw_n_i,
  input  logic [3:0]  req_reg_i,
  input  logic [7:0]  req_data_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  output logic        phi0_o,
  output logic        phi1_posedge_o,
  output logic        phi1_negedge_o,
  output logic [15:0] addr_o,
  output logic [7:0]  data_o,
  output logic        rw_n_o,
  output logic        dev_select_n_o,
  output logic [2:0]  slot_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_rd_en_i
);

  localparam int             CW       = $clog2(2*HALF_CYCLES);
  localparam logic [CW-1:0]  CNT_HALF = CW'(HALF_CYCLES);
  localparam logic [CW-1:0]  CNT_AEND = CW'(HALF_CYCLES-1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(2*HALF_CYCLES-1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_HOLD} state_e;

  typedef struct packed {
    logic       rw_n;
    logic [3:0] rg;
    logic [7:0] data;
  } req_t;

  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic          pend_vld_q, pend_vld_d;
  req_t          pend_q, pend_d;
  req_t          act_q, act_d;
  logic          drain;

  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          rw_n_q, rw_n_d;
  logic          dsel_n_q, dsel_n_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          bus_act;

  // Bus timing runs regardless of traffic so cards always see a clean phi clock.
  assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    act_d      = act_q;
    drain      = 1'b0;
    case (state_q)
      S_IDLE: if (pend_vld_q && cnt_q == CNT_LAST) begin
                state_d = S_ADDR;
                drain   = 1'b1;
              end
      S_ADDR: if (cnt_q == CNT_AEND) state_d = S_DATA;
      S_DATA: if (cnt_q == CNT_LAST) state_d = S_HOLD;
      S_HOLD: begin
                if (pend_vld_q) begin
                  state_d = S_ADDR;
                  drain   = 1'b1;
                end else begin
                  state_d = S_IDLE;
                end
              end
      default: state_d = S_IDLE;
    endcase
    if (drain) begin
      act_d      = pend_q;
      pend_vld_d = 1'b0;
    end
    // Accept and drain never coincide: drain needs a full holder, accept an empty one.
    if (req_valid_i && !pend_vld_q) begin
      pend_vld_d = 1'b1;
      pend_d     = '{rw_n: req_rw_n_i, rg: req_reg_i, data: req_data_i};
    end
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_comb begin
    bus_act    = (state_d != S_IDLE);
    addr_d     = bus_act ? {8'hC0, 1'b1, SLOT, act_d.rg} : 16'h0000;
    rw_n_d     = bus_act ? act_d.rw_n : 1'b1;
    data_d     = bus_act ? act_d.data : 8'h00;
    dsel_n_d   = !(state_d == S_DATA || state_d == S_HOLD);
    rsp_vld_d  = (state_q == S_DATA) && (cnt_q == CNT_LAST) && act_q.rw_n;
    rsp_data_d = rsp_data_q;
    if (rsp_vld_d) rsp_data_d = bus_rd_en_i ? bus_data_i : FLOAT_DATA;
  end

  always_ff @(posedge clk_logic_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      act_q      <= '0;
      addr_q     <= 16'h0000;
      data_q     <= 8'h00;
      rw_n_q     <= 1'b1;
      dsel_n_q   <= 1'b1;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= 8'h00;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rw_n_q     <= rw_n_d;
      dsel_n_q   <= dsel_n_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign req_ready_o    = !pend_vld_q;
  assign rsp_valid_o    = rsp_vld_q;
  assign rsp_data_o     = rsp_data_q;
  assign phi0_o         = (cnt_q >= CNT_HALF);
  assign phi1_posedge_o = (cnt_q == '0);
  assign phi1_negedge_o = (cnt_q == CNT_HALF);
  assign addr_o         = addr_q;
  assign data_o         = data_q;
  assign rw_n_o         = rw_n_q;
  assign dev_select_n_o = dsel_n_q;
  assign slot_o         = SLOT;

endmodule
